// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, width defaults and MEM/WB bubble for the memory stage
package pipe_pkg;
  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  typedef struct packed {
    logic regwr;
    logic memtoreg;
  } wb_ctrl_t;
  localparam wb_ctrl_t BUBBLE = '{regwr: 1'b0, memtoreg: 1'b0};
endpackage

// File: rtl/dmem_handshake.sv
// dmem_handshake: req/ack data-memory FSM with timeout counter and registered request lines
module dmem_handshake
  import pipe_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          Resetn,
  input  logic          mem_op,
  input  logic          we,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          stall,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          err_timeout,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata
);
  localparam int CW = $clog2(TIMEOUT);
  state_t state;
  logic [CW-1:0] cnt;
  logic start, expire;
  assign start  = state == IDLE && mem_op && addr[1:0] == 2'b00;
  assign done   = state == WAIT && dmem_ack;
  assign expire = state == WAIT && !dmem_ack && cnt == CW'(TIMEOUT - 1);
  // the ack cycle and the abandoning cycle both let upstream advance
  assign stall  = start || (state == WAIT && !dmem_ack && !expire);
  assign rdata  = dmem_rdata;
  // issue on an aligned request, hold lines while waiting, drop on ack or timeout
  always_ff @(negedge CLK or negedge Resetn)
    if (!Resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      err_timeout <= 1'b0;
    end else if (start) begin
      state      <= WAIT;
      cnt        <= '0;
      dmem_req   <= 1'b1;
      dmem_we    <= we;
      dmem_addr  <= addr;
      dmem_wdata <= wdata;
    end else if (done || expire) begin
      state    <= IDLE;
      dmem_req <= 1'b0;
      if (expire) err_timeout <= 1'b1;
    end else if (state == WAIT) begin
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage with data-memory handshake, PC select and MEM/WB register
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int RW      = RW_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          Resetn,
  input  logic          MemWr,
  input  logic          MemtoReg,
  input  logic          Regwr,
  input  logic          Branch,
  input  logic          Jump,
  input  logic          zero,
  input  logic [DW-1:0] Target,
  input  logic [DW-1:0] ALUout,
  input  logic [DW-1:0] busB,
  input  logic [RW-1:0] Rd,
  output logic          PCsrc,
  output logic [DW-1:0] PC_target,
  output logic          stall,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          Regwr_wb,
  output logic          MemtoReg_wb,
  output logic [DW-1:0] ALUout_wb,
  output logic [DW-1:0] MemData_wb,
  output logic [RW-1:0] Rd_wb,
  output logic          err_align,
  output logic          err_timeout
);
  logic mem_op, done, keep;
  logic [DW-1:0] rdata;
  wb_ctrl_t ctrl_nxt;
  assign mem_op    = MemWr | MemtoReg;
  assign keep      = done || !mem_op;
  assign PCsrc     = Jump | (Branch & zero);
  assign PC_target = Target;
  dmem_handshake #(.DW(DW), .TIMEOUT(TIMEOUT)) u_hs (
    .CLK        (CLK),
    .Resetn     (Resetn),
    .mem_op     (mem_op),
    .we         (MemWr),
    .addr       (ALUout),
    .wdata      (busB),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .stall      (stall),
    .done       (done),
    .rdata      (rdata),
    .err_timeout(err_timeout),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata)
  );
  // completed accesses and non-memory ops write back; a store never writes the register file
  always_comb ctrl_nxt = done    ? wb_ctrl_t'{regwr: Regwr & ~MemWr, memtoreg: MemtoReg}
                       : !mem_op ? wb_ctrl_t'{regwr: Regwr, memtoreg: MemtoReg}
                       : BUBBLE;
  // MEM/WB register; anything stalled, misaligned or abandoned becomes a zeroed bubble
  always_ff @(negedge CLK or negedge Resetn)
    if (!Resetn) begin
      Regwr_wb    <= 1'b0;
      MemtoReg_wb <= 1'b0;
      ALUout_wb   <= '0;
      MemData_wb  <= '0;
      Rd_wb       <= '0;
      err_align   <= 1'b0;
    end else begin
      Regwr_wb    <= ctrl_nxt.regwr;
      MemtoReg_wb <= ctrl_nxt.memtoreg;
      ALUout_wb   <= keep ? ALUout : '0;
      MemData_wb  <= (done && !MemWr) ? rdata : '0;
      Rd_wb       <= keep ? Rd : '0;
      err_align   <= mem_op && ALUout[1:0] != 2'b00;
    end
endmodule
